// File: rtl/aes_round_iter.sv
// aes_round_iter: iterative AES-style round engine.
// A job whitens the 128-bit key with ROUND_CONST and then pushes it R times
// through a single registered round stage. The stage computes
//   one_round(rk, v) = MixColumns(ShiftRows(SubBytes(v))) ^ rk
// using the standard AES byte order: byte 0 sits in bits [127:120], and the
// state is laid out column-major, so byte index = 4*column + row.

module aes_one_round (
  input  logic         clk,
  input  logic         i_en,
  input  logic [127:0] i_roundKey,
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] term;
    acc  = 8'h00;
    term = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ term;
      term = xtime(term);
    end
    return acc;
  endfunction

  // The S-box is built algebraically: the inverse is x^254 (zero maps to
  // zero), formed as x^2 * x^4 * ... * x^128, followed by the AES affine map.
  function automatic logic [7:0] sBox(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      pw  = gfMul(pw, pw);
      inv = gfMul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mixColumn(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  logic [127:0] w_sub;
  logic [127:0] w_shift;
  logic [127:0] w_mix;
  logic [127:0] w_next;
  logic [127:0] r_state;

  // Combinational round: substitute, rotate rows left by their index, mix columns, add key.
  always_comb begin
    w_sub   = '0;
    w_shift = '0;
    w_mix   = '0;
    for (int i = 0; i < 16; i++) begin
      w_sub[127-8*i -: 8] = sBox(i_state[127-8*i -: 8]);
    end
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        w_shift[127-8*(row+4*col) -: 8] = w_sub[127-8*(row+4*((col+row)%4)) -: 8];
      end
    end
    for (int col = 0; col < 4; col++) begin
      w_mix[127-32*col -: 32] = mixColumn(w_shift[127-32*col -: 32]);
    end
    w_next = w_mix ^ i_roundKey;
  end

  // Pipeline register of the round; deliberately unreset, the controller never exposes it raw.
  always_ff @(posedge clk) begin
    if (i_en) r_state <= w_next;
  end

  assign o_state = r_state;

endmodule

module aes_round_iter #(
  parameter int unsigned  MAX_ROUNDS  = 40,
  parameter logic [127:0] ROUND_CONST = 128'hc2f45dfa_8acd3f4d_a3dcfe8a_93cefa0a
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [7:0]   in_rounds,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [7:0]   round_idx
);

  localparam logic [7:0] MaxRounds8 = 8'(MAX_ROUNDS);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  state_t       r_state;
  logic [7:0]   r_rounds;
  logic [7:0]   r_roundIdx;
  logic [127:0] r_outData;

  logic         w_accept;
  logic [7:0]   w_effRounds;
  logic         w_stageEn;
  logic [127:0] w_operand;
  logic [127:0] w_roundOut;

  // Abort wins over a simultaneous request, so nothing is accepted in that cycle.
  assign w_accept = in_valid && (r_state == StIdle) && !abort;

  // Zero and oversize requests both fall back to the configured ceiling.
  always_comb begin
    w_effRounds = in_rounds;
    if ((in_rounds == 8'd0) || (in_rounds > MaxRounds8)) w_effRounds = MaxRounds8;
  end

  // The accept edge already produces v1, so the stage only advances while
  // fewer than R rounds sit in its register; it then parks on vR until the
  // capture edge, giving R+1 edges from accept to out_valid.
  assign w_stageEn = w_accept ||
                     ((r_state == StRun) &&
                      (({1'b0, r_roundIdx} + 9'd1) < {1'b0, r_rounds}));

  assign w_operand = (r_state == StIdle) ? (in_key ^ ROUND_CONST) : w_roundOut;

  aes_one_round u_round (
    .clk        (clk),
    .i_en       (w_stageEn),
    .i_roundKey (ROUND_CONST),
    .i_state    (w_operand),
    .o_state    (w_roundOut)
  );

  // Job controller: accept, count rounds, capture the result, hand it off or abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_rounds   <= 8'd0;
      r_roundIdx <= 8'd0;
      r_outData  <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_rounds   <= w_effRounds;
            r_roundIdx <= 8'd0;
            r_state    <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            r_roundIdx <= 8'd0;
            r_state    <= StIdle;
          end else if (r_roundIdx == r_rounds) begin
            r_outData <= w_roundOut;
            r_state   <= StDone;
          end else begin
            r_roundIdx <= r_roundIdx + 8'd1;
          end
        end
        StDone: begin
          if (abort || out_ready) begin
            r_roundIdx <= 8'd0;
            r_state    <= StIdle;
          end
        end
        default: begin
          r_roundIdx <= 8'd0;
          r_state    <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign round_idx = r_roundIdx;
  assign out_data  = r_outData;

endmodule
